// File: rtl/zombie_lane_engine.sv
// Purpose: per-lane zombie tracker (spawn, tick-driven leftward march, kill, sticky loss) with a pixel hit output.
// Latency: zombie_pixel/zombie_lane are registered one cycle after hCount/vCount; lane state updates on the next edge.
// Backpressure: spawn_ready is combinational and refuses busy, out-of-range or post-loss spawns; kills never stall.
module zombie_lane_engine #(
    parameter int NUM_LANES   = 5,
    parameter int X_W         = 10,
    parameter int LANE_TOP    = 160,
    parameter int LANE_H      = 128,
    parameter int SPAWN_X     = 600,
    parameter int END_OF_LAWN = 0,
    parameter int ZOMBIE_W    = 32,
    parameter int TICK_DIV    = 500000,
    parameter int STEP        = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 run,
    input  logic                 spawn_valid,
    input  logic [2:0]           spawn_lane,
    output logic                 spawn_ready,
    input  logic                 kill_valid,
    input  logic [2:0]           kill_lane,
    input  logic [X_W-1:0]       hCount,
    input  logic [X_W-1:0]       vCount,
    output logic                 zombie_pixel,
    output logic [2:0]           zombie_lane,
    output logic [NUM_LANES-1:0] lane_active,
    output logic                 lost,
    output logic [15:0]          zombies_killed
);

    localparam int               DIV_W       = $clog2(TICK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST    = DIV_W'(TICK_DIV - 1);
    localparam logic [X_W-1:0]   SPAWN_XV    = X_W'(SPAWN_X);
    localparam logic [X_W-1:0]   END_XV      = X_W'(END_OF_LAWN);
    localparam logic [X_W-1:0]   STEP_V      = X_W'(STEP);
    // Smallest X that can still take a full step without reaching the end of the lawn.
    localparam logic [X_W:0]     MOVE_MIN    = (X_W+1)'(END_OF_LAWN + STEP + 1);
    localparam logic [X_W:0]     SPRITE_SPAN = (X_W+1)'(ZOMBIE_W - 1);
    localparam logic [3:0]       LANES_V     = 4'(NUM_LANES);

    typedef enum logic {
        ST_PLAY = 1'b0,
        ST_LOST = 1'b1
    } state_t;

    state_t               state_q;
    logic                 lost_q;
    logic [DIV_W-1:0]     div_q, div_d;
    logic [NUM_LANES-1:0] active_q, active_d;
    logic [X_W-1:0]       x_q [NUM_LANES];
    logic [X_W-1:0]       x_d [NUM_LANES];
    logic [15:0]          kills_q, kills_d;
    logic                 pix_q, pix_d;
    logic [2:0]           pix_lane_q, pix_lane_d;

    logic                 play;
    logic                 tick;
    logic [7:0]           active_pad;
    logic                 spawn_in_range;
    logic                 kill_in_range;
    logic                 kill_fire;
    logic [NUM_LANES-1:0] kill_hit;
    logic [NUM_LANES-1:0] spawn_hit;
    logic                 loss_evt;
    logic [NUM_LANES-1:0] lane_hit;
    logic [31:0]          v32;
    logic [X_W:0]         h_ext;

    assign play       = (state_q == ST_PLAY);
    assign active_pad = 8'(active_q);

    // Movement divider: counts only while running in PLAY, one-cycle tick on the last count.
    always_comb begin
        tick  = 1'b0;
        div_d = div_q;
        if (play && run) begin
            if (div_q == DIV_LAST) begin
                tick  = 1'b1;
                div_d = '0;
            end else begin
                div_d = div_q + 1'b1;
            end
        end
    end

    // Request qualification: lane indices are padded to 8 so out-of-range lanes read as inactive.
    always_comb begin
        spawn_in_range = ({1'b0, spawn_lane} < LANES_V);
        kill_in_range  = ({1'b0, kill_lane} < LANES_V);
        spawn_ready    = play && spawn_in_range && !active_pad[spawn_lane];
        kill_fire      = kill_valid && play && kill_in_range && active_pad[kill_lane];
    end

    // Per-lane decode of which lane the spawn/kill request targets this cycle.
    always_comb begin
        kill_hit  = '0;
        spawn_hit = '0;
        for (int k = 0; k < NUM_LANES; k++) begin
            kill_hit[k]  = kill_fire && (kill_lane == 3'(k));
            spawn_hit[k] = spawn_valid && spawn_ready && (spawn_lane == 3'(k));
        end
    end

    // Lane next state: kill beats tick, spawn (only possible on an idle lane) beats tick, else march.
    always_comb begin
        active_d = active_q;
        loss_evt = 1'b0;
        for (int k = 0; k < NUM_LANES; k++) begin
            x_d[k] = x_q[k];
            if (kill_hit[k]) begin
                active_d[k] = 1'b0;
            end else if (spawn_hit[k]) begin
                active_d[k] = 1'b1;
                x_d[k]      = SPAWN_XV;
            end else if (tick && active_q[k]) begin
                if ({1'b0, x_q[k]} >= MOVE_MIN) begin
                    x_d[k] = x_q[k] - STEP_V;
                end else begin
                    // Clamp at the lawn edge instead of stepping past it.
                    x_d[k]   = END_XV;
                    loss_evt = 1'b1;
                end
            end
        end
    end

    // Kill counter saturates rather than wrapping.
    always_comb begin
        kills_d = kills_q;
        if (kill_fire && (kills_q != 16'hFFFF)) begin
            kills_d = kills_q + 16'd1;
        end
    end

    // Stage-1 pixel hit; widened sums keep X+ZOMBIE_W-1 from overflowing near the right edge.
    always_comb begin
        lane_hit = '0;
        v32      = 32'(vCount);
        h_ext    = {1'b0, hCount};
        for (int k = 0; k < NUM_LANES; k++) begin
            lane_hit[k] = active_q[k]
                       && (v32 >= 32'(LANE_TOP + k * LANE_H))
                       && (v32 <  32'(LANE_TOP + (k + 1) * LANE_H))
                       && (h_ext >= {1'b0, x_q[k]})
                       && (h_ext <= ({1'b0, x_q[k]} + SPRITE_SPAN));
        end
    end

    // Priority pick: scanning downward leaves the lowest hitting lane as the winner.
    always_comb begin
        pix_d      = 1'b0;
        pix_lane_d = 3'd0;
        for (int k = NUM_LANES - 1; k >= 0; k--) begin
            if (lane_hit[k]) begin
                pix_d      = 1'b1;
                pix_lane_d = 3'(k);
            end
        end
    end

    // Game FSM: PLAY until the first loss event, then LOST until reset; lost is a registered output.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_PLAY;
            lost_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_PLAY: begin
                    if (loss_evt) begin
                        state_q <= ST_LOST;
                        lost_q  <= 1'b1;
                    end
                end
                ST_LOST: begin
                    state_q <= ST_LOST;
                    lost_q  <= 1'b1;
                end
                default: begin
                    state_q <= ST_PLAY;
                    lost_q  <= 1'b0;
                end
            endcase
        end
    end

    // Divider, lane positions/flags and kill counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_q    <= '0;
            active_q <= '0;
            kills_q  <= 16'd0;
            for (int k = 0; k < NUM_LANES; k++) begin
                x_q[k] <= SPAWN_XV;
            end
        end else begin
            div_q    <= div_d;
            active_q <= active_d;
            kills_q  <= kills_d;
            for (int k = 0; k < NUM_LANES; k++) begin
                x_q[k] <= x_d[k];
            end
        end
    end

    // Pixel output register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pix_q      <= 1'b0;
            pix_lane_q <= 3'd0;
        end else begin
            pix_q      <= pix_d;
            pix_lane_q <= pix_lane_d;
        end
    end

    assign zombie_pixel   = pix_q;
    assign zombie_lane    = pix_lane_q;
    assign lane_active    = active_q;
    assign lost           = lost_q;
    assign zombies_killed = kills_q;

endmodule

// File: doc/zombie_lane_engine.md
Name: zombie_lane_engine

Overview:
- Parametrised successor to the fixed five-lane zombie mover in the VGA bitchange path.
- Tracks NUM_LANES independent zombies, one per lawn lane: spawn, per-tick leftward march, kill, and a sticky loss condition.
- Produces a registered per-pixel zombie hit for the colour mux, plus a kill counter.
- Sits between the game-control FSM (spawn/kill/pause requests) and the rgb priority mux.

Parameters:
- NUM_LANES, 5, number of lawn lanes/zombie slots (1..8)
- X_W, 10, width of hCount/vCount and zombie X registers
- LANE_TOP, 160, vCount of first lane's top row
- LANE_H, 128, lane height in rows; lane k spans [LANE_TOP+k*LANE_H, LANE_TOP+(k+1)*LANE_H-1]
- SPAWN_X, 600, X loaded on spawn (left edge of sprite)
- END_OF_LAWN, 0, X at or below which a zombie causes loss
- ZOMBIE_W, 32, sprite width in pixels
- TICK_DIV, 500000, clk cycles per movement tick (>=2)
- STEP, 1, pixels moved per tick (1..15)

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- run  in  1  1 = tick divider counts; 0 = paused (divider and positions hold)
- spawn_valid  in  1  spawn request
- spawn_lane  in  3  target lane index
- spawn_ready  out  1  combinational: lost==0 and spawn_lane<NUM_LANES and lane spawn_lane inactive
- kill_valid  in  1  kill request (projectile hit)
- kill_lane  in  3  lane to kill
- hCount  in  X_W  current pixel column
- vCount  in  X_W  current pixel row
- zombie_pixel  out  1  registered: current pixel lies on an active zombie
- zombie_lane  out  3  registered: lane index of that zombie (0 when zombie_pixel=0)
- lane_active  out  NUM_LANES  per-lane active flags
- lost  out  1  sticky loss flag
- zombies_killed  out  16  saturating kill count

Behaviour:
- Global reset (reset_n low, async): all lanes inactive, all X = SPAWN_X, divider = 0, lost = 0, zombies_killed = 0, zombie_pixel = 0, zombie_lane = 0.
- Game FSM: PLAY -> LOST on loss event. LOST exits only via reset_n.
- In LOST: positions freeze, the divider holds, spawns are refused, and kills are ignored. Pixel output continues so frozen zombies stay drawn.
- Divider:
  - Counts 0..TICK_DIV-1 while run=1 and state=PLAY.
  - tick is asserted for one cycle when the count equals TICK_DIV-1; the count then wraps to 0.
- Spawn:
  - On spawn_valid && spawn_ready at a clock edge, the lane becomes active with X = SPAWN_X the next cycle.
  - spawn_lane >= NUM_LANES is never ready.
- Kill:
  - On kill_valid with kill_lane active and state=PLAY, the lane goes inactive and zombies_killed increments, saturating at 16'hFFFF.
  - A kill on an inactive or out-of-range lane is a no-op.
- Move: on tick, each active lane not killed this cycle updates X:
  - If X >= END_OF_LAWN+STEP+1: X -= STEP.
  - Otherwise X = END_OF_LAWN and a loss event fires.
  - No wrap-around/underflow is ever permitted.
- Simultaneous events, same lane, same cycle:
  - Kill + tick: kill wins; no move, no loss.
  - Kill + spawn: spawn is not ready (lane active at cycle start); kill executes.
  - Spawn + tick on an inactive lane: spawn wins, X = SPAWN_X.
  - Loss in one lane + kill in another, same cycle: both take effect (count increments, lost=1).
- Pixel path:
  - Stage-1 combinational hit: active[k] && vCount in lane k band && hCount in [X_k, X_k+ZOMBIE_W-1], computed with X_W+1-bit sums so no overflow.
  - Lowest-index lane wins (bands are disjoint, so this only matters for mis-parametrisation).
  - Registered with 1-cycle latency to zombie_pixel/zombie_lane.
  - Rows/columns outside every band give zombie_pixel=0.
- reset_n mid-tick or mid-frame: immediate clear; the divider restarts from 0 after release.

Test Plan:
- Reset release, run=1, TICK_DIV=4, spawn lane 2 -> lane_active=00100, X=600. After 4 ticks (16 cycles), X=596, lost=0.
- Active lane 1 at X=600, hCount=610, vCount=300 -> zombie_pixel=1, zombie_lane=1 one cycle later. hCount=632 or vCount=416 -> zombie_pixel=0.
- Kill lane 3 while active, coincident with tick -> lane 3 inactive, X unchanged, zombies_killed=1. Repeat the kill on the now-inactive lane -> count stays 1.
- STEP=3, lane 0 X=2, tick -> X=0, lost=1 next cycle. Subsequent spawn_ready=0, kills ignored, X values frozen for 100 ticks.
- run=0 for 50 cycles mid-count -> no X change, divider holds. After run=1, the next tick occurs after the remaining count.
- zombies_killed preset near saturation via 65535 kills (or a forced value) -> an additional kill holds at 16'hFFFF. Assert reset_n low mid-operation -> all outputs return to reset values asynchronously.
